reqgnt_wb_bridge: RTL and testbench

- Parametrised successor to the single-core req/gnt-to-Wishbone glue used in the processorci top-levels.
- Arbitrates NUM_PORTS harv-style memory request ports (imem, dmem, debug, DMA, ...) round-robin onto one Wishbone classic master.
- Generates byte selects and lane-replicated write data from a size code, and rejects misaligned accesses locally.
- Returns ack/err per port; an optional watchdog terminates hung bus cycles.

---
 rtl/reqgnt_wb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/reqgnt_wb_bridge.sv | 119 +++++++++++
 tb/tb_reqgnt_wb_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reqgnt_wb_pkg.sv
// reqgnt_wb_pkg: size codes, bridge FSM states and lane helpers shared by the req/gnt-to-Wishbone bridge.
package reqgnt_wb_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  function automatic logic [3:0] calc_sel(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a :
           size == SZ_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] d);
    return size == SZ_BYTE ? {4{d[7:0]}} : size == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction

  // size codes 10 and 11 are both word accesses
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_HALF ? a[0] : size[1] ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i, wrapping.
module rr_arbiter import reqgnt_wb_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PW-1:0]        idx_o
);
  logic w_found;

  // scan two laps starting at ptr so the wrap needs no modular pointer arithmetic
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    w_found = 1'b0;
    for (int k = 0; k < 2 * NUM_PORTS; k++)
      if (!w_found && k >= int'(ptr_i) && req_i[k % NUM_PORTS]) begin
        w_found = 1'b1;
        gnt_o[k % NUM_PORTS] = 1'b1;
        idx_o = PW'(k % NUM_PORTS);
      end
  end
endmodule

// File: rtl/reqgnt_wb_bridge.sv
// reqgnt_wb_bridge: round-robin req/gnt ports onto one Wishbone classic master.
// Define BRIDGE_TIMEOUT_EN to enable the hung-cycle watchdog.
module reqgnt_wb_bridge import reqgnt_wb_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS-1:0]        wren_i,
  input  logic [2*NUM_PORTS-1:0]      size_i,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr_i,
  input  logic [32*NUM_PORTS-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        err_o,
  output logic [31:0]                 rdata_o,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [3:0]                  wb_sel_o,
  output logic [ADDR_W-1:0]           wb_adr_o,
  output logic [31:0]                 wb_dat_o,
  input  logic [31:0]                 wb_dat_i,
  input  logic                        wb_ack_i,
  input  logic                        wb_err_i
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, w_idx;
  logic [NUM_PORTS-1:0] w_oh, r_oh;
  logic r_err, r_we, w_we, w_to, w_mis;
  logic [3:0] r_sel;
  logic [1:0] w_size;
  logic [ADDR_W-1:0] r_adr, w_addr;
  logic [31:0] r_dat, r_rdata, w_wdata;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
    .req_i(req_i), .ptr_i(r_ptr), .gnt_o(w_oh), .idx_o(w_idx)
  );

  always_comb begin
    w_size = '0;
    w_addr = '0;
    w_wdata = '0;
    w_we = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_oh[i]) begin
        w_size = size_i[2*i +: 2];
        w_addr = addr_i[ADDR_W*i +: ADDR_W];
        w_wdata = wdata_i[32*i +: 32];
        w_we = wren_i[i];
      end
  end

  assign w_mis = is_misaligned(w_size, w_addr[1:0]);

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_cnt <= '0;
    else r_cnt <= r_state == BUS ? r_cnt + 1'b1 : '0;

  assign w_to = TIMEOUT_CYCLES != 0 && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  // watchdog compiled out; the parameter stays so both builds share one interface
  assign w_to = TIMEOUT_CYCLES < 0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = ~|req_i ? IDLE : w_mis ? ERR : BUS;
      BUS: w_next = wb_ack_i || wb_err_i || w_to ? DONE : BUS;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_oh <= '0;
      r_err <= 1'b0;
      r_rdata <= '0;
      r_we <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |req_i) begin
        r_ptr <= w_idx == PW'(NUM_PORTS - 1) ? '0 : w_idx + 1'b1;
        r_oh <= w_oh;
        r_we <= w_we;
        r_sel <= calc_sel(w_size, w_addr[1:0]);
        r_adr <= {w_addr[ADDR_W-1:2], 2'b00};
        r_dat <= replicate_wdata(w_size, w_wdata);
      end
      // a slave termination in the same cycle as the watchdog takes precedence
      if (r_state == BUS) begin
        r_err <= wb_err_i || (!wb_ack_i && w_to);
        r_rdata <= wb_dat_i;
      end
    end

  assign wb_cyc_o = r_state == BUS;
  assign wb_stb_o = r_state == BUS;
  assign wb_we_o = r_we;
  assign wb_sel_o = r_sel;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign rdata_o = r_rdata;
  assign gnt_o = r_state == DONE && !r_err ? r_oh : '0;
  assign err_o = (r_state == DONE && r_err) || r_state == ERR ? r_oh : '0;
endmodule

// File: tb/tb_reqgnt_wb_bridge.sv
// tb_reqgnt_wb_bridge: directed vector table, round-robin/reset/watchdog sequences and a randomized
// two-port run against a lane-level reference model of the bridge.
module tb_reqgnt_wb_bridge;
  localparam int NP = 2;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic [NP-1:0] req_i = '0, wren_i = '0;
  logic [2*NP-1:0] size_i = '0;
  logic [32*NP-1:0] addr_i = '0, wdata_i = '0;
  logic [NP-1:0] gnt_o, err_o;
  logic [31:0] rdata_o, wb_dat_o, wb_adr_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0] wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0;

  reqgnt_wb_bridge #(.NUM_PORTS(NP), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .wren_i(wren_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .err_o(err_o), .rdata_o(rdata_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_fail = 0;

  // slave: terminates s_delay cycles into the cycle; mode 0 ack, 1 err, 2 both, 3 never
  int s_delay = 0, s_mode = 0, s_cnt = 0;
  always @(negedge clk_i) begin
    if (wb_cyc_o) begin
      wb_ack_i = s_cnt == s_delay && (s_mode == 0 || s_mode == 2);
      wb_err_i = s_cnt == s_delay && (s_mode == 1 || s_mode == 2);
      s_cnt++;
    end else begin
      s_cnt = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    req_i[p] = 1'b1;
    wren_i[p] = we;
    size_i[2*p +: 2] = sz;
    addr_i[32*p +: 32] = a;
    wdata_i[32*p +: 32] = wd;
  endtask

  int cap_lat;
  logic cap_bus, cap_we;
  logic [3:0] cap_sel;
  logic [31:0] cap_adr, cap_dat, cap_rd;
  logic [NP-1:0] cap_g, cap_e;

  // counts negedges from the request until a pulse; captures the first bus cycle
  task automatic wait_pulse();
    cap_lat = 0;
    cap_bus = 1'b0;
    cap_g = '0;
    cap_e = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      cap_lat++;
      if (wb_cyc_o && !cap_bus) begin
        cap_bus = 1'b1;
        cap_we = wb_we_o;
        cap_sel = wb_sel_o;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        chk("stb_with_cyc", wb_stb_o, 1);
      end
      if (|gnt_o || |err_o) begin
        cap_g = gnt_o;
        cap_e = err_o;
        cap_rd = rdata_o;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL pulse_wait: no gnt/err within 40 cycles, expected one");
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int base = int'(a % 4) / n * n;
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) s[i] = i >= base && i < base + n;
    return s;
  endfunction

  function automatic logic [31:0] ref_dat(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
    return d;
  endfunction

  typedef struct {
    int port; logic we; logic [1:0] sz; logic [31:0] addr, wdata, rdata;
    int delay, mode; logic [3:0] sel; logic [31:0] adr, dat; logic [1:0] g, e; int lat;
  } vec_t;

  vec_t tv[11];

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic pend[NP];
    logic p_we[NP];
    logic [1:0] p_sz[NP];
    logic [31:0] p_addr[NP], p_wd[NP], exp_rd;
    int m_ptr, w, mr;
    logic mis;
    logic [NP-1:0] oh;

    tv[0]  = '{0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0,      1, 0, 4'hF, 32'h100, 32'hDEADBEEF, 2'b01, 2'b00, 3};
    tv[1]  = '{1, 1'b0, 2'b00, 32'h203, 32'h000000A5, 32'h11223344, 0, 0, 4'h8, 32'h200, 32'hA5A5A5A5, 2'b10, 2'b00, 2};
    tv[2]  = '{0, 1'b1, 2'b01, 32'h11,  32'h00001234, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,        2'b00, 2'b01, 1};
    tv[3]  = '{0, 1'b1, 2'b10, 32'h12,  32'h12345678, 32'h0,      0, 0, 4'h0, 32'h0,   32'h0,        2'b00, 2'b01, 1};
    tv[4]  = '{1, 1'b1, 2'b01, 32'h22,  32'h1234BEEF, 32'h0,      2, 0, 4'hC, 32'h20,  32'hBEEFBEEF, 2'b10, 2'b00, 4};
    tv[5]  = '{0, 1'b1, 2'b00, 32'h41,  32'h0000005A, 32'h0,      0, 0, 4'h2, 32'h40,  32'h5A5A5A5A, 2'b01, 2'b00, 2};
    tv[6]  = '{0, 1'b0, 2'b10, 32'h80,  32'h0,        32'hCAFEF00D, 1, 2, 4'hF, 32'h80, 32'h0,       2'b00, 2'b01, 3};
    tv[7]  = '{1, 1'b1, 2'b10, 32'hC,   32'h0BADC0DE, 32'h0,      0, 1, 4'hF, 32'hC,   32'h0BADC0DE, 2'b00, 2'b10, 2};
    tv[8]  = '{0, 1'b1, 2'b11, 32'h3FC, 32'h76543210, 32'h0,      0, 0, 4'hF, 32'h3FC, 32'h76543210, 2'b01, 2'b00, 2};
    tv[9]  = '{1, 1'b0, 2'b00, 32'h2,   32'h000000FF, 32'h89ABCDEF, 3, 0, 4'h4, 32'h0,  32'hFFFFFFFF, 2'b10, 2'b00, 5};
    tv[10] = '{1, 1'b0, 2'b01, 32'h3,   32'h0,        32'h0,      0, 0, 4'h0, 32'h0,   32'h0,        2'b00, 2'b10, 1};

    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_rdata", rdata_o, 0);
    rstn_i = 1'b1;

    // both ports request continuously from reset: strict alternation starting at port 0
    @(negedge clk_i);
    s_delay = 0;
    s_mode = 0;
    set_port(0, 1'b1, 2'b10, 32'h1000, 32'h11111111);
    set_port(1, 1'b1, 2'b10, 32'h2000, 32'h22222222);
    for (int t = 0; t < 4; t++) begin
      wait_pulse();
      chk($sformatf("rr%0d_gnt", t), cap_g, t % 2 ? 2'b10 : 2'b01);
      chk($sformatf("rr%0d_adr", t), cap_adr, t % 2 ? 32'h2000 : 32'h1000);
      chk($sformatf("rr%0d_dat", t), cap_dat, t % 2 ? 32'h22222222 : 32'h11111111);
    end
    req_i = '0;

    // single-port directed vectors
    for (int v = 0; v < 11; v++) begin
      @(negedge clk_i);
      s_delay = tv[v].delay;
      s_mode = tv[v].mode;
      wb_dat_i = tv[v].rdata;
      set_port(tv[v].port, tv[v].we, tv[v].sz, tv[v].addr, tv[v].wdata);
      wait_pulse();
      chk($sformatf("v%0d_gnt", v), cap_g, tv[v].g);
      chk($sformatf("v%0d_err", v), cap_e, tv[v].e);
      chk($sformatf("v%0d_lat", v), cap_lat, tv[v].lat);
      chk($sformatf("v%0d_bus", v), cap_bus, tv[v].lat > 1);
      if (tv[v].lat > 1) begin
        chk($sformatf("v%0d_sel", v), cap_sel, tv[v].sel);
        chk($sformatf("v%0d_adr", v), cap_adr, tv[v].adr);
        chk($sformatf("v%0d_dat", v), cap_dat, tv[v].dat);
        chk($sformatf("v%0d_we", v), cap_we, tv[v].we);
      end
      if (tv[v].g != 0) chk($sformatf("v%0d_rdata", v), cap_rd, tv[v].rdata);
      req_i = '0;
    end

`ifdef BRIDGE_TIMEOUT_EN
    // watchdog: 8 bus cycles with no termination, then an error pulse
    @(negedge clk_i);
    s_mode = 3;
    set_port(1, 1'b0, 2'b10, 32'h600, 32'h0);
    wait_pulse();
    chk("to_lat", cap_lat, 9);
    chk("to_err", cap_e, 2'b10);
    chk("to_gnt", cap_g, 2'b00);
    req_i = '0;
`endif

    // randomized two-port traffic; the last served port was 1, so the pointer is back at 0
    @(negedge clk_i);
    m_ptr = 0;
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < NP; p++)
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          pend[p] = 1'b1;
          p_we[p] = 1'($urandom_range(1, 0));
          p_sz[p] = 2'($urandom_range(3, 0));
          p_addr[p] = $urandom;
          p_wd[p] = $urandom;
          set_port(p, p_we[p], p_sz[p], p_addr[p], p_wd[p]);
        end
      if (!pend[0] && !pend[1]) begin
        w = int'($urandom_range(NP - 1, 0));
        pend[w] = 1'b1;
        p_we[w] = 1'b0;
        p_sz[w] = 2'b10;
        p_addr[w] = $urandom & 32'hFFFFFFFC;
        p_wd[w] = $urandom;
        set_port(w, p_we[w], p_sz[w], p_addr[w], p_wd[w]);
      end
      s_delay = int'($urandom_range(3, 0));
      mr = int'($urandom_range(9, 0));
      s_mode = mr < 7 ? 0 : mr < 9 ? 1 : 2;
      exp_rd = $urandom;
      wb_dat_i = exp_rd;
      w = -1;
      for (int k = 0; k < NP; k++) if (w < 0 && pend[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
      m_ptr = (w + 1) % NP;
      oh = '0;
      oh[w] = 1'b1;
      mis = ref_mis(p_sz[w], p_addr[w]);
      wait_pulse();
      chk($sformatf("r%0d_gnt", it), cap_g, !mis && s_mode == 0 ? oh : '0);
      chk($sformatf("r%0d_err", it), cap_e, mis || s_mode != 0 ? oh : '0);
      chk($sformatf("r%0d_bus", it), cap_bus, !mis);
      if (!mis) begin
        chk($sformatf("r%0d_sel", it), cap_sel, ref_sel(p_sz[w], p_addr[w]));
        chk($sformatf("r%0d_adr", it), cap_adr, p_addr[w] & 32'hFFFFFFFC);
        chk($sformatf("r%0d_dat", it), cap_dat, ref_dat(p_sz[w], p_wd[w]));
        chk($sformatf("r%0d_we", it), cap_we, p_we[w]);
        if (s_mode == 0) chk($sformatf("r%0d_rdata", it), cap_rd, exp_rd);
      end
      pend[w] = 1'b0;
      req_i[w] = 1'b0;
    end
    req_i = '0;

    // hung cycle on port 0 (pointer moves to 1), then reset mid-cycle
    repeat (2) @(negedge clk_i);
    s_mode = 3;
    set_port(0, 1'b0, 2'b10, 32'h300, 32'h0);
    for (int i = 0; i < 10 && !wb_cyc_o; i++) @(negedge clk_i);
    chk("hang_cyc", wb_cyc_o, 1);
`ifndef BRIDGE_TIMEOUT_EN
    repeat (20) @(negedge clk_i);
    chk("hang_cyc_held", wb_cyc_o, 1);
    chk("hang_no_pulse", gnt_o | err_o, 0);
`endif
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_cyc", wb_cyc_o, 0);
    chk("arst_stb", wb_stb_o, 0);
    chk("arst_gnt", gnt_o, 0);
    chk("arst_err", err_o, 0);
    @(negedge clk_i);
    req_i = '0;
    s_mode = 0;
    s_delay = 0;
    rstn_i = 1'b1;
    @(negedge clk_i);
    set_port(0, 1'b0, 2'b10, 32'h400, 32'h0);
    set_port(1, 1'b0, 2'b10, 32'h500, 32'h0);
    wait_pulse();
    chk("post_rst_gnt", cap_g, 2'b01);
    chk("post_rst_adr", cap_adr, 32'h400);
    req_i = '0;
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
